// File: rtl/md_unit_pkg.sv
// Shared opcodes, default latencies and opcode-class helpers for the multiply/divide unit.
// Optional MADD/MADDU support is enabled by defining MD_MADD_EN.
package md_unit_pkg;

    typedef logic [3:0] md_op_t;

    localparam md_op_t MD_MULT  = 4'd0;
    localparam md_op_t MD_MULTU = 4'd1;
    localparam md_op_t MD_DIV   = 4'd2;
    localparam md_op_t MD_DIVU  = 4'd3;
    localparam md_op_t MD_MFHI  = 4'd4;
    localparam md_op_t MD_MFLO  = 4'd5;
    localparam md_op_t MD_MTHI  = 4'd6;
    localparam md_op_t MD_MTLO  = 4'd7;
    localparam md_op_t MD_MADD  = 4'd8;
    localparam md_op_t MD_MADDU = 4'd9;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Opcodes that launch a multi-cycle computation; anything else is a no-op on start.
    function automatic logic md_is_start(md_op_t op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU:                  return 1'b1;
`endif
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic md_is_div(md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage request/response bundle between the pipeline and the multiply/divide unit.
interface md_unit_if;
    import md_unit_pkg::*;

    logic        start;
    md_op_t      md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_hilo;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport master (output start, md_op, a, b, we_hilo,
                    input  busy, hi, lo, md_out);
    modport slave  (input  start, md_op, a, b, we_hilo,
                    output busy, hi, lo, md_out);
endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath; result is {hi, lo}, valid=0 means leave HI/LO alone.
// The hi/lo accumulator inputs only exist when MD_MADD_EN is defined.
module md_calc
    import md_unit_pkg::*;
(
    input  md_op_t      md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MD_MADD_EN
    input  logic [31:0] hi,
    input  logic [31:0] lo,
`endif
    output logic [63:0] result,
    output logic        valid
);
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quo_s, rem_s;
    logic        [31:0] quo_u, rem_u;
    logic               div_ovf;

    assign prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u  = {32'd0, a} * {32'd0, b};
    assign quo_s   = $signed(a) / $signed(b);
    assign rem_s   = $signed(a) % $signed(b);
    assign quo_u   = a / b;
    assign rem_u   = a % b;
    // Most-negative / -1 overflows the signed quotient; pin it to the MIPS-defined answer.
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        result = '0;
        valid  = 1'b0;
        case (md_op)
            MD_MULT:  begin result = prod_s; valid = 1'b1; end
            MD_MULTU: begin result = prod_u; valid = 1'b1; end
            MD_DIV: begin
                valid  = (b != 32'd0);
                result = div_ovf ? {32'd0, 32'h8000_0000} : {rem_s, quo_s};
            end
            MD_DIVU: begin
                valid  = (b != 32'd0);
                result = {rem_u, quo_u};
            end
`ifdef MD_MADD_EN
            MD_MADD:  begin result = {hi, lo} + prod_s; valid = 1'b1; end
            MD_MADDU: begin result = {hi, lo} + prod_u; valid = 1'b1; end
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, busy-counter latency model, MT/MF access.
// Define MD_MADD_EN to add MADD/MADDU accumulate operations.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 15) ? $clog2(MAX_CYCLES + 1) : 4;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        hi_q, lo_q, hi_tmp, lo_tmp;
    logic               commit_tmp;
    logic [63:0]        calc_result;
    logic               calc_valid;
    logic               launch, finish;

    md_calc u_calc (
        .md_op  (bus.md_op),
        .a      (bus.a),
        .b      (bus.b),
`ifdef MD_MADD_EN
        .hi     (hi_q),
        .lo     (lo_q),
`endif
        .result (calc_result),
        .valid  (calc_valid)
    );

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: if (bus.start && md_is_start(bus.md_op)) begin
                launch     = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: if (cnt == CNT_W'(1)) begin
                finish     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // The shadow result is reset too, so an aborted operation can never leak into HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            hi_tmp     <= '0;
            lo_tmp     <= '0;
            commit_tmp <= 1'b0;
        end else if (launch) begin
            {hi_tmp, lo_tmp} <= calc_result;
            commit_tmp       <= calc_valid;
            cnt              <= md_is_div(bus.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (state == S_RUN) begin
            cnt <= cnt - CNT_W'(1);
            if (finish && commit_tmp) begin
                hi_q <= hi_tmp;
                lo_q <= lo_tmp;
            end
        end else if (bus.we_hilo && !bus.start) begin
            if (bus.md_op == MD_MTHI) hi_q <= bus.a;
            if (bus.md_op == MD_MTLO) lo_q <= bus.a;
        end
    end

    always_comb begin
        case (bus.md_op)
            MD_MFHI: bus.md_out = hi_q;
            MD_MFLO: bus.md_out = lo_q;
            default: bus.md_out = '0;
        endcase
    end

    assign bus.busy = (state == S_RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO/latency queued at launch, checked when busy falls.
// Exercises MADD/MADDU only when MD_MADD_EN is defined.
module tb_md_unit;
    import md_unit_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    logic [31:0] m_hi, m_lo;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input md_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi,
                          input logic [31:0] e_lo, input int cycles);
        exp_t e;
        int   n;
        sb.push_back('{hi: e_hi, lo: e_lo, cycles: cycles});
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.md_op = MD_MFHI;
        check({tag, "_hold_hi"}, bus.hi, m_hi);
        check({tag, "_hold_lo"}, bus.lo, m_lo);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check({tag, "_busy_cycles"}, n, e.cycles);
        check({tag, "_hi"}, bus.hi, e.hi);
        check({tag, "_lo"}, bus.lo, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic mt_write(input md_op_t op, input logic [31:0] val);
        @(negedge clk);
        bus.we_hilo = 1'b1; bus.md_op = op; bus.a = val;
        @(negedge clk);
        bus.we_hilo = 1'b0;
        if (op == MD_MTHI) m_hi = val;
        else               m_lo = val;
        check("mt_hi", bus.hi, m_hi);
        check("mt_lo", bus.lo, m_lo);
    endtask

    task automatic noop_start(input string tag, input md_op_t op);
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = op; bus.a = 32'h1234; bus.b = 32'h5;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_hi"}, bus.hi, m_hi);
        check({tag, "_lo"}, bus.lo, m_lo);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] rp;
        reset = 1'b1;
        bus.start = 1'b0; bus.md_op = MD_MULT; bus.a = '0; bus.b = '0; bus.we_hilo = 1'b0;
        m_hi = '0; m_lo = '0;
        #12;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
        run_op("multu_big", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            rp = {32'd0, ra} * {32'd0, rb};
            run_op("rnd_multu", MD_MULTU, ra, rb, rp[63:32], rp[31:0], 5);
            rb = $urandom_range(1, 1000);
            run_op("rnd_divu", MD_DIVU, ra, rb, ra % rb, ra / rb, 10);
        end

        mt_write(MD_MTHI, 32'h11);
        mt_write(MD_MTLO, 32'h22);
        run_op("div0", MD_DIV, 32'd55, 32'd0, 32'h11, 32'h22, 10);
        run_op("divu0", MD_DIVU, 32'd55, 32'd0, 32'h11, 32'h22, 10);

        noop_start("unk_op", 4'hF);
        noop_start("mf_start", MD_MFHI);

        // Async reset mid-multiply: registers clear immediately, pending result dropped.
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = MD_MULTU; bus.a = 32'h1_0000; bus.b = 32'h1_0000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_busy_before", bus.busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_hi", bus.hi, 32'd0);
        check("rst_mid_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (15) @(negedge clk);
        check("rst_nocommit_busy", bus.busy, 1'b0);
        check("rst_nocommit_hi", bus.hi, 32'd0);
        check("rst_nocommit_lo", bus.lo, 32'd0);

        mt_write(MD_MTLO, 32'hDEAD);
        mt_write(MD_MTHI, 32'hBEEF);
        @(negedge clk);
        bus.md_op = MD_MFLO;
        #1 check("mflo", bus.md_out, 32'hDEAD);
        bus.md_op = MD_MFHI;
        #1 check("mfhi", bus.md_out, 32'hBEEF);
        bus.md_op = MD_DIV;
        #1 check("mf_other", bus.md_out, 32'd0);

`ifdef MD_MADD_EN
        mt_write(MD_MTHI, 32'd0);
        mt_write(MD_MTLO, 32'hFFFF_FFFF);
        run_op("madd", MD_MADD, 32'd2, 32'd3, 32'd1, 32'd5, 5);
        run_op("madd_neg", MD_MADD, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd4, 5);
        run_op("maddu", MD_MADDU, 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3, 5);
`else
        noop_start("madd_off", MD_MADD);
        noop_start("maddu_off", MD_MADDU);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
